// File: rtl/adc_seq_controller.sv
// adc_seq_controller: sequences the modular ADC through its MM bridge and boxcar-averages the response stream per channel.
module adc_seq_controller #(
  parameter int NUM_CH = 8,
  parameter int AVG_LOG2 = 4,
  parameter logic [9:0] SEQ_CMD_ADDR = 10'h000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic        mode_cont,
  input  logic        stop,
  output logic        busy,
  output logic [9:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [15:0] avm_writedata,
  output logic [1:0]  avm_byteenable,
  output logic        avm_burstcount,
  input  logic        avm_waitrequest,
  input  logic        rsp_valid,
  input  logic        rsp_startofpacket,
  input  logic        rsp_endofpacket,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  output logic        res_valid,
  output logic [4:0]  res_channel,
  output logic [11:0] res_data,
  output logic [7:0]  drop_cnt
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [5:0] NCH = 6'(NUM_CH);
  typedef enum logic [1:0] {IDLE, WR_START, RUN, WR_STOP} state_t;
  state_t state, state_nx;
  logic mode_q;
  logic [AW-1:0] acc [NUM_CH];
  logic [CW-1:0] cnt [NUM_CH];
  logic [IW-1:0] ch;
  logic [AW-1:0] sum;
  logic take, drop, last, accept;
  logic unused_sop;
  assign unused_sop = rsp_startofpacket;
  assign busy = state != IDLE;
  assign avm_read = 1'b0;
  assign avm_byteenable = 2'b11;
  assign avm_burstcount = 1'b1;
  assign accept = state == IDLE && start;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) mode_q <= mode_cont;
    end
  end
  always_comb begin
    state_nx = state;
    avm_write = 1'b0;
    avm_address = '0;
    avm_writedata = '0;
    case (state)
      IDLE: state_nx = start ? WR_START : IDLE;
      WR_START: begin
        avm_write = 1'b1;
        avm_address = SEQ_CMD_ADDR;
        avm_writedata = {12'h0, mode_q ? 3'b000 : 3'b001, 1'b1};
        state_nx = avm_waitrequest ? WR_START : RUN;
      end
      RUN: begin
        // single runs end on the sequencer's last slot; the hardware clears its own run bit
        if (mode_q && stop) state_nx = WR_STOP;
        else if (!mode_q && rsp_valid && rsp_endofpacket) state_nx = IDLE;
      end
      WR_STOP: begin
        avm_write = 1'b1;
        avm_address = SEQ_CMD_ADDR;
        state_nx = avm_waitrequest ? WR_STOP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign ch = rsp_channel[IW-1:0];
  assign take = rsp_valid && (state == RUN || state == WR_STOP) && {1'b0, rsp_channel} < NCH;
  assign drop = rsp_valid && !take;
  assign sum = acc[ch] + AW'(rsp_data);
  assign last = cnt[ch] == CNT_LAST;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc <= '{default: '0};
      cnt <= '{default: '0};
      res_valid <= 1'b0;
      res_channel <= '0;
      res_data <= '0;
      drop_cnt <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        acc <= '{default: '0};
        cnt <= '{default: '0};
        drop_cnt <= '0;
      end else begin
        if (take && last) begin
          acc[ch] <= '0;
          cnt[ch] <= '0;
          res_valid <= 1'b1;
          res_channel <= rsp_channel;
          res_data <= 12'(sum >> AVG_LOG2);
        end else if (take) begin
          acc[ch] <= sum;
          cnt[ch] <= cnt[ch] + 1'b1;
        end
        if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adc_seq_controller.sv
// tb_adc_seq_controller: directed bench driving an AVG_LOG2=2 and an AVG_LOG2=4 instance from shared stimulus.
module tb_adc_seq_controller;
  logic clk = 0, rst_n = 0;
  logic start = 0, mode_cont = 0, stop = 0, waitreq = 0;
  logic rsp_valid = 0, rsp_sop = 0, rsp_eop = 0;
  logic [4:0] rsp_channel = 0;
  logic [11:0] rsp_data = 0;
  logic busy_a, avm_write_a, avm_read_a, avm_burst_a, res_valid_a;
  logic [9:0] avm_address_a;
  logic [15:0] avm_writedata_a;
  logic [1:0] avm_be_a;
  logic [4:0] res_channel_a;
  logic [11:0] res_data_a;
  logic [7:0] drop_cnt_a;
  logic busy_b, avm_write_b, avm_read_b, avm_burst_b, res_valid_b;
  logic [9:0] avm_address_b;
  logic [15:0] avm_writedata_b;
  logic [1:0] avm_be_b;
  logic [4:0] res_channel_b;
  logic [11:0] res_data_b;
  logic [7:0] drop_cnt_b;
  int checks = 0, errors = 0;
  int nres_a = 0, nres_b = 0, nwr = 0, lch_b = 0, ldat_b = 0;
  always #5 clk = ~clk;
  adc_seq_controller #(.AVG_LOG2(2)) u_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .mode_cont(mode_cont), .stop(stop),
    .busy(busy_a), .avm_address(avm_address_a), .avm_write(avm_write_a), .avm_read(avm_read_a),
    .avm_writedata(avm_writedata_a), .avm_byteenable(avm_be_a), .avm_burstcount(avm_burst_a),
    .avm_waitrequest(waitreq), .rsp_valid(rsp_valid), .rsp_startofpacket(rsp_sop),
    .rsp_endofpacket(rsp_eop), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .res_valid(res_valid_a), .res_channel(res_channel_a), .res_data(res_data_a), .drop_cnt(drop_cnt_a));
  adc_seq_controller u_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .mode_cont(mode_cont), .stop(stop),
    .busy(busy_b), .avm_address(avm_address_b), .avm_write(avm_write_b), .avm_read(avm_read_b),
    .avm_writedata(avm_writedata_b), .avm_byteenable(avm_be_b), .avm_burstcount(avm_burst_b),
    .avm_waitrequest(waitreq), .rsp_valid(rsp_valid), .rsp_startofpacket(rsp_sop),
    .rsp_endofpacket(rsp_eop), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .res_valid(res_valid_b), .res_channel(res_channel_b), .res_data(res_data_b), .drop_cnt(drop_cnt_b));
  always @(negedge clk) begin
    if (res_valid_a) nres_a++;
    if (res_valid_b) begin
      nres_b++;
      lch_b = int'(res_channel_b);
      ldat_b = int'(res_data_b);
    end
    if (avm_write_a && !waitreq) nwr++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int c, input int d, input bit eop);
    rsp_valid = 1;
    rsp_channel = 5'(c);
    rsp_data = 12'(d);
    rsp_eop = eop;
    step();
    rsp_valid = 0;
    rsp_eop = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int nw, base_a;
    repeat (2) step();
    check("rst_busy", busy_a, 0);
    check("rst_write", avm_write_a, 0);
    check("rst_be", avm_be_a, 3);
    check("rst_burst", avm_burst_b, 1);
    check("rst_res", {res_valid_a, res_channel_a, res_data_a}, 0);
    check("rst_drop", drop_cnt_b, 0);
    rst_n = 1;
    step();
    waitreq = 1;
    start = 1;
    mode_cont = 0;
    step();
    start = 0;
    check("st_addr", avm_address_a, 0);
    check("st_data", avm_writedata_a, 16'h0003);
    check("st_busy", busy_a, 1);
    nw = 0;
    repeat (6) begin
      if (avm_write_a) nw++;
      if (nw == 4) waitreq = 0;
      step();
    end
    check("st_wr_cycles", nw, 4);
    check("run_busy", busy_a, 1);
    check("st_wr_done", nwr, 1);
    send(1, 100, 0);
    send(1, 101, 0);
    send(1, 102, 0);
    send(1, 103, 1);
    check("sgl_valid", res_valid_a, 1);
    check("sgl_ch", res_channel_a, 1);
    check("sgl_data", res_data_a, 101);
    check("sgl_idle", busy_a, 0);
    step();
    check("sgl_pulse", res_valid_a, 0);
    check("sgl_hold", res_data_a, 101);
    check("sgl_cnt_a", nres_a, 1);
    check("sgl_cnt_b", nres_b, 0);
    start = 1;
    step();
    start = 0;
    step();
    check("ign_run", busy_a, 1);
    start = 1;
    step();
    start = 0;
    stop = 1;
    step();
    stop = 0;
    check("ign_write", avm_write_a, 0);
    check("ign_busy", busy_a, 1);
    check("ign_nwr", nwr, 2);
    send(3, 5, 1);
    check("ign_end", busy_a, 0);
    start = 1;
    mode_cont = 1;
    step();
    start = 0;
    check("ct_data", avm_writedata_b, 16'h0001);
    step();
    base_a = nres_a;
    for (int i = 0; i < 16; i++) begin
      send(0, 4095, 0);
      send(2, 4095, 0);
    end
    check("ct_valid", res_valid_b, 1);
    check("ct_ch", res_channel_b, 2);
    check("ct_data_b", res_data_b, 4095);
    step();
    check("ct_cnt_b", nres_b, 2);
    check("ct_last", {lch_b[4:0], ldat_b[11:0]}, {5'd2, 12'd4095});
    check("ct_cnt_a", nres_a - base_a, 8);
    stop = 1;
    step();
    stop = 0;
    check("sp_write", avm_write_a, 1);
    check("sp_data", avm_writedata_a, 0);
    check("sp_busy", busy_b, 1);
    step();
    check("sp_idle", busy_b, 0);
    check("sp_nwr", nwr, 4);
    check("drop_clr", drop_cnt_a, 0);
    base_a = nres_a;
    send(9, 1, 0);
    send(3, 1, 0);
    step();
    check("drop_two", drop_cnt_a, 2);
    check("drop_nores", nres_a - base_a, 0);
    repeat (300) send(9, 0, 0);
    check("drop_sat", drop_cnt_b, 255);
    start = 1;
    step();
    start = 0;
    step();
    check("rs_dclr", drop_cnt_a, 0);
    send(9, 0, 0);
    check("rs_drun", drop_cnt_a, 1);
    repeat (3) send(1, 4000, 0);
    rst_n = 0;
    #2;
    check("rs_busy", busy_a, 0);
    check("rs_drop", drop_cnt_a, 0);
    check("rs_res", res_data_a, 0);
    check("rs_write", avm_write_b, 0);
    step();
    rst_n = 1;
    step();
    start = 1;
    mode_cont = 0;
    step();
    start = 0;
    step();
    send(1, 8, 0);
    send(1, 9, 0);
    send(1, 10, 0);
    send(1, 11, 1);
    check("rs_valid", res_valid_a, 1);
    check("rs_avg", res_data_a, 9);
    check("rs_ch", res_channel_a, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_seq_controller.md
Name: adc_seq_controller

Overview:
- Avalon-MM master and stream sink that sequences the modular ADC subsystem through its 16-bit MM bridge.
- Writes the sequencer command register to start a single-cycle or continuous conversion run.
- Consumes the ADC response stream and keeps one accumulator per channel.
- Emits a boxcar-averaged result per channel every 2^AVG_LOG2 samples; sits between user control logic and the ADC subsystem.

Parameters:
- NUM_CH, 8, channels 0..NUM_CH-1 are averaged; any other channel number is dropped.
- AVG_LOG2, 4, log2 of samples per average (legal range 0..4).
- SEQ_CMD_ADDR, 10'h000, bridge address of the sequencer command register.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; ignored unless busy=0
- mode_cont  in  1  sampled with start: 1 = continuous, 0 = single-cycle
- stop  in  1  one-cycle request to end a continuous run
- busy  out  1  high from start acceptance until return to IDLE
- avm_address  out  10  MM bridge address
- avm_write  out  1  write strobe
- avm_read  out  1  tied 0
- avm_writedata  out  16  command word
- avm_byteenable  out  2  always 2'b11
- avm_burstcount  out  1  always 1
- avm_waitrequest  in  1  bridge stall
- rsp_valid  in  1  response valid
- rsp_startofpacket  in  1  response SOP (unused)
- rsp_endofpacket  in  1  response EOP, marks last sequencer slot
- rsp_channel  in  5  response channel number
- rsp_data  in  12  response sample
- res_valid  out  1  one-cycle pulse, averaged result available
- res_channel  out  5  channel of the result
- res_data  out  12  averaged result
- drop_cnt  out  8  count of responses dropped, saturating

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0 except avm_byteenable=2'b11 and avm_burstcount=1; accumulators, sample counters and drop_cnt cleared.
- FSM states: IDLE, WR_START, RUN, WR_STOP.
- IDLE:
  - start=1 -> WR_START next cycle.
  - Latch mode_cont.
  - Clear all accumulators and counters, including drop_cnt.
  - busy=1 from the following cycle.
- WR_START:
  - avm_write=1, avm_address=SEQ_CMD_ADDR, avm_writedata={12'h0, mode, 1'b1}, where mode = 3'b000 if continuous, 3'b001 if single.
  - Signals held stable while avm_waitrequest=1.
  - Write completes on the first cycle with avm_write=1 and avm_waitrequest=0 -> RUN; avm_write deasserts on the next cycle.
- RUN:
  - Single mode: a valid response with rsp_endofpacket=1 is processed, then -> IDLE next cycle; the sequencer self-clears its run bit.
  - Continuous mode: stop=1 -> WR_STOP.
- WR_STOP:
  - Same handshake as WR_START with writedata=16'h0000.
  - On completion -> IDLE, busy=0.
  - stop is ignored in every state other than RUN in continuous mode.
  - start is ignored while busy=1.
- Sample path, active in RUN and WR_STOP:
  - On rsp_valid with rsp_channel<NUM_CH: acc[ch] += rsp_data, cnt[ch] += 1.
  - Accumulator width is 12+AVG_LOG2; it cannot overflow.
  - When cnt[ch] reaches 2^AVG_LOG2 - 1 and a further sample arrives:
    - sum = acc[ch] + rsp_data.
    - Next cycle: res_valid=1, res_channel=ch, res_data=sum>>AVG_LOG2 (truncating).
    - acc[ch] and cnt[ch] reset to 0 in that same update.
  - Result latency is 1 cycle after the completing sample. At most one result per cycle, since there is at most one sample per cycle.
  - rsp_channel>=NUM_CH, or rsp_valid in IDLE/WR_START: sample discarded, drop_cnt += 1, saturating at 255.
- Reset mid-run: aborts immediately, with no stop write issued. Software must re-issue start; the first write after reset re-programs the sequencer.
- res_data and res_channel hold their last value when res_valid=0.

Test Plan:
- Reset then start, mode_cont=0, waitrequest held 3 cycles -> avm_write high 4 cycles, addr 0x000, data 0x0003, busy=1; RUN entered after the handshake.
- Single mode, AVG_LOG2=2, channel 1 fed 100,101,102,103 with EOP on the 4th -> one res_valid, ch=1, data=101; FSM returns to IDLE, busy=0 one cycle later.
- Continuous mode, channels 0 and 2 interleaved, 16 samples each of 4095 at AVG_LOG2=4 -> two results of 4095, no overflow; stop -> write 0x0000, then IDLE.
- Channel 9 response while NUM_CH=8 and while in IDLE -> drop_cnt=2, no result; 300 such samples saturate drop_cnt at 255.
- start asserted during RUN and stop asserted in single mode -> both ignored, with no extra bus writes.
- reset_reset_n pulsed low mid-accumulation -> all outputs 0 immediately; restart yields a fresh average unaffected by prior partial sums.
